// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one operand bit pair per clock, LSB first, through a
// full adder built from two half_adder cells. Result and carry are registered at completion.

module half_adder (
    input  logic a_in,
    input  logic b_in,
    output logic sum_out,
    output logic carry_out
);
    assign sum_out   = a_in ^ b_in;
    assign carry_out = a_in & b_in;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic             carry_q,  carry_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;

    logic ha0_sum_s, ha0_carry_s;
    logic fa_sum_s,  ha1_carry_s;
    logic fa_cout_s;

    half_adder u_ha0 (
        .a_in      (a_sr_q[0]),
        .b_in      (b_sr_q[0]),
        .sum_out   (ha0_sum_s),
        .carry_out (ha0_carry_s)
    );

    half_adder u_ha1 (
        .a_in      (ha0_sum_s),
        .b_in      (carry_q),
        .sum_out   (fa_sum_s),
        .carry_out (ha1_carry_s)
    );

    assign fa_cout_s = ha0_carry_s | ha1_carry_s;

    // Next-state and datapath decode for the serial add sequence
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        sum_d    = sum_q;
        cout_d   = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    a_sr_d   = a_in;
                    b_sr_d   = b_in;
                    res_sr_d = {WIDTH{1'b0}};
                    carry_d  = 1'b0;
                    cnt_d    = CNT_ZERO;
                    state_d  = ST_ADD;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_ADD: begin
                res_sr_d = {fa_sum_s, res_sr_q[WIDTH-1:1]};
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                carry_d  = fa_cout_s;
                cnt_d    = cnt_q + CNT_ONE;
                // Final bit: publish straight from the adder so no partial value is ever visible
                if (cnt_q == CNT_LAST) begin
                    sum_d   = {fa_sum_s, res_sr_q[WIDTH-1:1]};
                    cout_d  = fa_cout_s;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ADD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, shift registers and registered outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= {WIDTH{1'b0}};
            b_sr_q   <= {WIDTH{1'b0}};
            res_sr_q <= {WIDTH{1'b0}};
            carry_q  <= 1'b0;
            cnt_q    <= CNT_ZERO;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= {WIDTH{1'b0}};
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign busy_out  = busy_q;
    assign done_out  = done_q;
    assign sum_out   = sum_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl: an 8-bit instance for timing and
// protocol cases, and a 4-bit instance swept over every operand pair.

module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst;
    logic       start8;
    logic [7:0] a8, b8;
    logic       busy8, done8, carry8;
    logic [7:0] sum8;

    logic       start4;
    logic [3:0] a4, b4;
    logic       busy4, done4, carry4;
    logic [3:0] sum4;

    int n_cmp;
    int n_bad;
    int done4_cnt;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk_in    (clk),
        .rst_in    (rst),
        .start_in  (start8),
        .a_in      (a8),
        .b_in      (b8),
        .busy_out  (busy8),
        .done_out  (done8),
        .sum_out   (sum8),
        .carry_out (carry8)
    );

    serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
        .clk_in    (clk),
        .rst_in    (rst),
        .start_in  (start4),
        .a_in      (a4),
        .b_in      (b4),
        .busy_out  (busy4),
        .done_out  (done4),
        .sum_out   (sum4),
        .carry_out (carry4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done4) done4_cnt <= done4_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one 8-bit add, wait (bounded) for done, check latency and result.
    task automatic run_op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp_sum, input logic exp_c);
        int n;
        bit seen;
        a8 = a; b8 = b; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        seen = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            n = n + 1;
            if (done8) seen = 1'b1;
        end
        check_val({tag, "_done_seen"}, 32'(seen), 32'd1);
        check_val({tag, "_latency"}, 32'(n), 32'd8);
        check_val({tag, "_sum"}, 32'(sum8), 32'(exp_sum));
        check_val({tag, "_carry"}, 32'(carry8), 32'(exp_c));
        tick();
    endtask

    initial begin
        int dcnt;
        logic [7:0] cap_sum;
        logic cap_c;
        logic [4:0] exp5;
        bit seen;

        n_cmp = 0; n_bad = 0; done4_cnt = 0;
        rst = 1'b1;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        start4 = 1'b0; a4 = 4'h0; b4 = 4'h0;

        // Reset state
        tick();
        tick();
        check_val("rst_busy", 32'(busy8), 32'd0);
        check_val("rst_done", 32'(done8), 32'd0);
        check_val("rst_sum", 32'(sum8), 32'd0);
        check_val("rst_carry", 32'(carry8), 32'd0);
        rst = 1'b0;
        tick();

        // Basic timing: 0x35 + 0x4A, inputs scrambled after acceptance
        a8 = 8'h35; b8 = 8'h4A; start8 = 1'b1;
        tick();
        start8 = 1'b0; a8 = 8'hC3; b8 = 8'h9E;
        check_val("t1_busy_e0", 32'(busy8), 32'd1);
        check_val("t1_done_e0", 32'(done8), 32'd0);
        for (int e = 1; e <= 9; e++) begin
            tick();
            check_val($sformatf("t1_busy_e%0d", e), 32'(busy8), 32'(e <= 8));
            check_val($sformatf("t1_done_e%0d", e), 32'(done8), 32'(e == 8));
            if (e == 7) check_val("t1_sum_hold_e7", 32'(sum8), 32'd0);
            if (e == 8) begin
                check_val("t1_sum", 32'(sum8), 32'h7F);
                check_val("t1_carry", 32'(carry8), 32'd0);
            end
        end

        // Carry and boundary vectors
        run_op8("v_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
        run_op8("v_ff_ff", 8'hFF, 8'hFF, 8'hFE, 1'b1);
        run_op8("v_00_00", 8'h00, 8'h00, 8'h00, 1'b0);

        // Start during ADD is ignored
        a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
        tick();
        start8 = 1'b0; a8 = 8'h5A; b8 = 8'hC3;
        tick();
        tick();
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        dcnt = 0; cap_sum = 8'h00; cap_c = 1'b0;
        for (int e = 3; e <= 14; e++) begin
            tick();
            start8 = 1'b0;
            if (done8) begin
                dcnt = dcnt + 1;
                cap_sum = sum8;
                cap_c = carry8;
            end
        end
        check_val("t3_done_count", 32'(dcnt), 32'd1);
        check_val("t3_sum", 32'(cap_sum), 32'h30);
        check_val("t3_carry", 32'(cap_c), 32'd0);
        check_val("t3_idle_after", 32'(busy8), 32'd0);

        // start held high: back-to-back accepts every WIDTH+2 cycles
        a8 = 8'h01; b8 = 8'h02; start8 = 1'b1;
        tick();
        a8 = 8'h80; b8 = 8'h80;
        for (int e = 1; e <= 18; e++) begin
            tick();
            if (e == 8) begin
                check_val("t4_sum_a", 32'(sum8), 32'h03);
                check_val("t4_carry_a", 32'(carry8), 32'd0);
                check_val("t4_done_a", 32'(done8), 32'd1);
            end
            if (e == 9)  check_val("t4_busy_e9", 32'(busy8), 32'd0);
            if (e == 10) check_val("t4_busy_e10", 32'(busy8), 32'd1);
            if (e == 17) begin
                check_val("t4_sum_hold_e17", 32'(sum8), 32'h03);
                check_val("t4_done_e17", 32'(done8), 32'd0);
            end
            if (e == 18) begin
                check_val("t4_sum_b", 32'(sum8), 32'h00);
                check_val("t4_carry_b", 32'(carry8), 32'd1);
                check_val("t4_done_b", 32'(done8), 32'd1);
                start8 = 1'b0;
            end
        end
        tick();

        // Mid-operation asynchronous reset
        run_op8("pre_rst", 8'h12, 8'h34, 8'h46, 1'b0);
        a8 = 8'hAA; b8 = 8'h57; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        for (int e = 1; e <= 4; e++) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("t5_busy_async", 32'(busy8), 32'd0);
        check_val("t5_done_async", 32'(done8), 32'd0);
        check_val("t5_sum_async", 32'(sum8), 32'd0);
        check_val("t5_carry_async", 32'(carry8), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        dcnt = 0;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (done8 || busy8) dcnt = dcnt + 1;
        end
        check_val("t5_no_activity", 32'(dcnt), 32'd0);
        run_op8("t5_after", 8'h07, 8'h09, 8'h10, 1'b0);

        // Exhaustive 4-bit sweep
        for (int i = 0; i < 256; i++) begin
            a4 = 4'(i >> 4);
            b4 = 4'(i & 15);
            exp5 = {1'b0, a4} + {1'b0, b4};
            start4 = 1'b1;
            tick();
            start4 = 1'b0;
            seen = 1'b0;
            for (int k = 0; k < 12 && !seen; k++) begin
                tick();
                if (done4) seen = 1'b1;
            end
            check_val($sformatf("sw4_%02h", i), {27'd0, seen, carry4, sum4}, {27'd1, exp5});
            tick();
        end
        tick();
        check_val("sw4_done_count", 32'(done4_cnt), 32'd256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
